// File: rtl/axi_lp_ctrl.sv
// AXI low-power interface controller: one CSYSREQ/CSYSACK/CACTIVE handshake FSM per channel,
// with idle-based entry, deny/timeout sticky flags and aggregate status outputs.
module axi_lp_ctrl #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned TMO_CYC  = 64
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              lp_req_i,
  input  logic [NUM_CH-1:0] lp_en_i,
  input  logic [NUM_CH-1:0] clr_i,
  output logic [NUM_CH-1:0] csysreq_o,
  input  logic [NUM_CH-1:0] csysack_i,
  input  logic [NUM_CH-1:0] cactive_i,
  output logic [NUM_CH-1:0] lp_act_o,
  output logic [NUM_CH-1:0] deny_o,
  output logic [NUM_CH-1:0] tmo_o,
  output logic              all_lp_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {StRun, StReq, StLp, StWake} state_e;

  localparam logic [7:0] IdleThr = 8'(IDLE_CYC);
  // Flag fires on the edge the handshake counter steps onto TMO_CYC.
  localparam logic [7:0] TmoLast = 8'(TMO_CYC - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e     state_q, state_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] hs_q, hs_d;
    logic       deny_q, deny_d;
    logic       tmo_q, tmo_d;
    logic       busy, hs_enter, deny_set, tmo_set;
    logic       csysreq, lp_act;

    always_ff @(posedge aclk_i or posedge areset_i) begin
      if (areset_i) begin
        state_q <= StRun;
        idle_q  <= 8'd0;
        hs_q    <= 8'd0;
        deny_q  <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        hs_q    <= hs_d;
        deny_q  <= deny_d;
        tmo_q   <= tmo_d;
      end
    end

    // CSYSREQ may only toggle with CSYSACK at its resting level, so LP exit waits for ack low.
    always_comb begin
      state_d = state_q;
      case (state_q)
        StRun: begin
          if (lp_req_i && lp_en_i[i] && (idle_q >= IdleThr) && csysack_i[i]) state_d = StReq;
        end
        StReq: begin
          if (!csysack_i[i]) state_d = cactive_i[i] ? StWake : StLp;
        end
        StLp: begin
          if (!csysack_i[i] && (!lp_req_i || !lp_en_i[i] || cactive_i[i])) state_d = StWake;
        end
        StWake: begin
          if (csysack_i[i]) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end

    always_comb begin
      busy     = (state_q == StReq) || (state_q == StWake);
      hs_enter = (state_d != state_q) && ((state_d == StReq) || (state_d == StWake));
      deny_set = (state_q == StReq) && !csysack_i[i] && cactive_i[i];
      tmo_set  = busy && !hs_enter && (hs_q == TmoLast);

      idle_d = idle_q;
      if (cactive_i[i] || (state_q != StRun)) begin
        idle_d = 8'd0;
      end else if (idle_q != 8'hFF) begin
        idle_d = idle_q + 8'd1;
      end

      hs_d = hs_q;
      if (hs_enter) begin
        hs_d = 8'd0;
      end else if (busy && (hs_q != 8'hFF)) begin
        hs_d = hs_q + 8'd1;
      end

      deny_d = deny_set | (deny_q & ~clr_i[i]);
      tmo_d  = tmo_set | (tmo_q & ~clr_i[i]);
    end

    always_comb begin
      csysreq = (state_q == StRun) || (state_q == StWake);
      lp_act  = (state_q == StLp);
    end

    assign csysreq_o[i] = csysreq;
    assign lp_act_o[i]  = lp_act;
    assign deny_o[i]    = deny_q;
    assign tmo_o[i]     = tmo_q;
  end

  assign all_lp_o = (|lp_en_i) && (&(lp_act_o | ~lp_en_i));
  assign irq_o    = (|deny_o) || (|tmo_o);

endmodule

// File: tb/tb_axi_lp_ctrl.sv
// Directed bench for axi_lp_ctrl: a vector table for the main handshakes plus
// hand-written sequences for entry latency, timeout and asynchronous reset.
module tb_axi_lp_ctrl;

  logic       aclk = 1'b0;
  logic       areset = 1'b0;
  logic       lp_req = 1'b0;
  logic [1:0] lp_en = 2'b00;
  logic [1:0] clr = 2'b00;
  logic [1:0] csysreq;
  logic [1:0] csysack = 2'b11;
  logic [1:0] cactive = 2'b00;
  logic [1:0] lp_act;
  logic [1:0] deny;
  logic [1:0] tmo;
  logic       all_lp;
  logic       irq;

  int tests = 0;
  int fails = 0;

  axi_lp_ctrl #(
    .NUM_CH  (2),
    .IDLE_CYC(16),
    .TMO_CYC (64)
  ) dut (
    .aclk_i   (aclk),
    .areset_i (areset),
    .lp_req_i (lp_req),
    .lp_en_i  (lp_en),
    .clr_i    (clr),
    .csysreq_o(csysreq),
    .csysack_i(csysack),
    .cactive_i(cactive),
    .lp_act_o (lp_act),
    .deny_o   (deny),
    .tmo_o    (tmo),
    .all_lp_o (all_lp),
    .irq_o    (irq)
  );

  always #5 aclk = ~aclk;

  // {csysreq, lp_act, deny, tmo, all_lp, irq}
  logic [9:0] obs;
  assign obs = {csysreq, lp_act, deny, tmo, all_lp, irq};

  typedef struct {
    int         n;
    logic       lp_req;
    logic [1:0] en;
    logic [1:0] clr;
    logic [1:0] ack;
    logic [1:0] cact;
    logic [9:0] exp;
  } vec_t;

  vec_t vt[30];

  function automatic vec_t mk(int n, logic rq, logic [1:0] en, logic [1:0] cl, logic [1:0] ack,
                              logic [1:0] ca, logic [1:0] sr, logic [1:0] la, logic [1:0] dn,
                              logic [1:0] tm, logic al, logic iq);
    vec_t v;
    v.n = n; v.lp_req = rq; v.en = en; v.clr = cl; v.ack = ack; v.cact = ca;
    v.exp = {sr, la, dn, tm, al, iq};
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [1:0] en, input logic [1:0] cl,
                       input logic [1:0] ack, input logic [1:0] ca);
    lp_req = rq; lp_en = en; clr = cl; csysack = ack; cactive = ca;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    int first;
    int stayed;
    int n;

    //           n  rq en     clr    ack    cact   csysreq lp_act deny  tmo   all  irq
    vt[0]  = mk(16, 1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[1]  = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[2]  = mk(1,  1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0);
    vt[3]  = mk(3,  1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0);
    vt[4]  = mk(1,  0, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[5]  = mk(1,  0, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[6]  = mk(16, 1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[7]  = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[8]  = mk(1,  1, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 0, 1);
    vt[9]  = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 0, 1);
    vt[10] = mk(1,  1, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[11] = mk(16, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[12] = mk(1,  1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[13] = mk(1,  1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0);
    vt[14] = mk(1,  1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    vt[15] = mk(1,  1, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    vt[16] = mk(1,  0, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[17] = mk(1,  0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[18] = mk(16, 1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[19] = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[20] = mk(1,  0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[21] = mk(2,  0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[22] = mk(1,  0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0);
    vt[23] = mk(1,  0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[24] = mk(1,  0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[25] = mk(16, 1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[26] = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    vt[27] = mk(1,  1, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 0, 1);
    vt[28] = mk(1,  1, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 0, 1);
    vt[29] = mk(1,  1, 2'b01, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);

    // Reset values (lp_en all zero, so all_lp must stay low too)
    #1 areset = 1'b1;
    #1 check("reset_outputs", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    @(posedge aclk);
    @(posedge aclk);
    #1 areset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(vt[i].lp_req, vt[i].en, vt[i].clr, vt[i].ack, vt[i].cact);
      step(vt[i].n);
      check($sformatf("vec%0d", i), obs, vt[i].exp);
    end

    // Timeout: REQ held with ack high
    drive(1'b1, 2'b01, 2'b00, 2'b11, 2'b00);
    step(16);
    check("tmo_pre_req", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    step(1);
    check("tmo_req_entry", obs, {2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    first = -1;
    stayed = 1;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (tmo[0] && first < 0) first = k;
      if (csysreq[0] !== 1'b0) stayed = 0;
    end
    check_int("tmo_cycle", first, 64);
    check_int("tmo_csysreq_held", stayed, 1);
    check("tmo_flags", obs, {2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1});
    drive(1'b1, 2'b01, 2'b00, 2'b10, 2'b00);
    step(1);
    check("tmo_then_lp", obs, {2'b10, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1});
    drive(1'b0, 2'b01, 2'b00, 2'b10, 2'b00);
    step(1);
    drive(1'b0, 2'b01, 2'b00, 2'b11, 2'b00);
    step(1);
    check("tmo_sticky_run", obs, {2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1});
    drive(1'b0, 2'b01, 2'b01, 2'b11, 2'b00);
    step(1);
    check("tmo_clr", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    // Entry latency from CACTIVE falling
    drive(1'b1, 2'b01, 2'b00, 2'b11, 2'b01);
    step(2);
    drive(1'b1, 2'b01, 2'b00, 2'b11, 2'b00);
    n = 0;
    while (csysreq[0] !== 1'b0 && n < 40) begin
      step(1);
      n++;
    end
    check_int("entry_latency", n, 17);
    drive(1'b1, 2'b01, 2'b00, 2'b10, 2'b00);
    step(1);
    drive(1'b0, 2'b01, 2'b00, 2'b10, 2'b00);
    step(1);
    drive(1'b0, 2'b01, 2'b00, 2'b11, 2'b00);
    step(1);
    check("latency_back_run", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    // Reset while ch0 sits in WAKE (denied) and ch1 in LP
    drive(1'b1, 2'b11, 2'b00, 2'b11, 2'b11);
    step(1);
    drive(1'b1, 2'b11, 2'b00, 2'b11, 2'b00);
    step(17);
    check("rst_both_req", obs, {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
    step(1);
    check("rst_wake_lp", obs, {2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1});
    step(1);
    check("rst_wake_hold", obs, {2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1});
    #3 areset = 1'b1;
    #1 check("rst_async", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    @(posedge aclk);
    #1 areset = 1'b0;
    drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    step(20);
    check("rst_wait_ack", obs, {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    drive(1'b1, 2'b11, 2'b00, 2'b11, 2'b00);
    step(1);
    check("rst_then_req", obs, {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
